// File: rtl/reg_list_sequencer.sv
// Multi-register transfer sequencer for PUSH/POP/LDM/STM. It turns a captured register
// list into one transfer micro-op per cycle, then issues one base-register writeback.
//
//  state  | meaning
//  IDLE   | waiting for start_i; the accept cycle stalls the pipeline
//  SEQ    | one micro-op per cycle, lowest pending register first, extra register last
//  SP_UPD | one-cycle base writeback of 4 x count on register 13
module reg_list_sequencer #(
    parameter int ADDR_WIDTH = 4,
    parameter int WORD       = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic                  flush_i,
    input  logic                  is_load_i,
    input  logic [7:0]            reg_list_i,
    input  logic                  extra_reg_i,
    output logic                  stall_pipeline_o,
    output logic                  uop_valid_o,
    output logic                  uop_is_load_o,
    output logic [ADDR_WIDTH-1:0] reg_addr_o,
    output logic [WORD-1:0]       offset_o,
    output logic                  sp_update_o,
    output logic [WORD-1:0]       sp_adjust_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEQ    = 2'd1,
        SP_UPD = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      list_q, list_d;
    logic            extra_q, extra_d;
    logic            ld_q, ld_d;
    logic [3:0]      idx_q, idx_d;
    logic [WORD-1:0] adj_q, adj_d;

    logic [3:0]      cnt;
    logic [2:0]      sel;
    logic [7:0]      list_rest;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            list_q  <= '0;
            extra_q <= 1'b0;
            ld_q    <= 1'b0;
            idx_q   <= '0;
            adj_q   <= '0;
        end else begin
            state_q <= state_d;
            list_q  <= list_d;
            extra_q <= extra_d;
            ld_q    <= ld_d;
            idx_q   <= idx_d;
            adj_q   <= adj_d;
        end
    end

    always_comb begin
        cnt = {3'b000, extra_reg_i};
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'b000, reg_list_i[i]};
        end
        sel = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (list_q[i]) sel = 3'(i);
        end
        list_rest = list_q & ~(8'b1 << sel);
    end

    always_comb begin
        state_d          = state_q;
        list_d           = list_q;
        extra_d          = extra_q;
        ld_d             = ld_q;
        idx_d            = idx_q;
        adj_d            = adj_q;
        stall_pipeline_o = 1'b0;
        uop_valid_o      = 1'b0;
        uop_is_load_o    = 1'b0;
        reg_addr_o       = '0;
        offset_o         = '0;
        sp_update_o      = 1'b0;
        sp_adjust_o      = adj_q;
        busy_o           = 1'b0;

        // Outputs are forced low while reset is held, even against a live start_i.
        if (reset_i) begin
            busy_o = (state_q != IDLE);
            unique case (state_q)
                IDLE: begin
                    if (start_i && !flush_i) begin
                        stall_pipeline_o = 1'b1;
                        list_d           = reg_list_i;
                        extra_d          = extra_reg_i;
                        ld_d             = is_load_i;
                        idx_d            = '0;
                        adj_d            = WORD'({cnt, 2'b00});
                        state_d          = (cnt != 4'd0) ? SEQ : SP_UPD;
                    end
                end
                SEQ: begin
                    if (flush_i) begin
                        list_d  = '0;
                        extra_d = 1'b0;
                        state_d = IDLE;
                    end else begin
                        stall_pipeline_o = 1'b1;
                        uop_valid_o      = 1'b1;
                        uop_is_load_o    = ld_q;
                        offset_o         = WORD'({idx_q, 2'b00});
                        idx_d            = idx_q + 4'd1;
                        if (list_q != 8'd0) begin
                            reg_addr_o = ADDR_WIDTH'(sel);
                            list_d     = list_rest;
                            if (list_rest == 8'd0 && !extra_q) state_d = SP_UPD;
                        end else begin
                            reg_addr_o = ld_q ? ADDR_WIDTH'(15) : ADDR_WIDTH'(14);
                            extra_d    = 1'b0;
                            state_d    = SP_UPD;
                        end
                    end
                end
                SP_UPD: begin
                    if (!flush_i) begin
                        sp_update_o = 1'b1;
                        reg_addr_o  = ADDR_WIDTH'(13);
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_list_sequencer.sv
// Directed bench for reg_list_sequencer: a per-cycle vector table plus hand-written
// reset sequences.
module tb_reg_list_sequencer;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        start_i, flush_i, is_load_i, extra_reg_i;
    logic [7:0]  reg_list_i;
    logic        stall_pipeline_o, uop_valid_o, uop_is_load_o, sp_update_o, busy_o;
    logic [3:0]  reg_addr_o;
    logic [31:0] offset_o, sp_adjust_o;

    int n_cmp = 0;
    int n_bad = 0;

    reg_list_sequencer #(.ADDR_WIDTH(4), .WORD(32)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .flush_i(flush_i),
        .is_load_i(is_load_i), .reg_list_i(reg_list_i), .extra_reg_i(extra_reg_i),
        .stall_pipeline_o(stall_pipeline_o), .uop_valid_o(uop_valid_o),
        .uop_is_load_o(uop_is_load_o), .reg_addr_o(reg_addr_o), .offset_o(offset_o),
        .sp_update_o(sp_update_o), .sp_adjust_o(sp_adjust_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        start, flush, ld;
        logic [7:0]  list;
        logic        extra;
        logic        e_stall, e_valid, e_ld;
        logic [3:0]  e_addr;
        logic [31:0] e_off;
        logic        e_spu;
        logic [31:0] e_adj;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic f, input logic l, input logic [7:0] li,
                       input logic x, input logic es, input logic ev, input logic el,
                       input logic [3:0] ea, input logic [31:0] eo, input logic esp,
                       input logic [31:0] ead, input logic eb);
        vec_t v;
        v.start = s; v.flush = f; v.ld = l; v.list = li; v.extra = x;
        v.e_stall = es; v.e_valid = ev; v.e_ld = el; v.e_addr = ea; v.e_off = eo;
        v.e_spu = esp; v.e_adj = ead; v.e_busy = eb;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic es, input logic ev, input logic el,
                             input logic [3:0] ea, input logic [31:0] eo, input logic esp,
                             input logic [31:0] ead, input logic eb);
        check({tag, " stall"},   32'(stall_pipeline_o), 32'(es));
        check({tag, " valid"},   32'(uop_valid_o),      32'(ev));
        check({tag, " is_load"}, 32'(uop_is_load_o),    32'(el));
        check({tag, " addr"},    32'(reg_addr_o),       32'(ea));
        check({tag, " offset"},  offset_o,              eo);
        check({tag, " sp_upd"},  32'(sp_update_o),      32'(esp));
        check({tag, " adjust"},  sp_adjust_o,           ead);
        check({tag, " busy"},    32'(busy_o),           32'(eb));
    endtask

    task automatic drive(input logic s, input logic f, input logic l, input logic [7:0] li,
                         input logic x);
        start_i = s; flush_i = f; is_load_i = l; reg_list_i = li; extra_reg_i = x;
    endtask

    initial begin
        // PUSH {r0,r2,LR}
        add(1,0,0,8'h05,1, 1,0,0, 4'd0,  0, 0,  0, 0);
        add(0,0,0,8'h00,0, 1,1,0, 4'd0,  0, 0, 12, 1);
        add(0,0,0,8'h00,0, 1,1,0, 4'd2,  4, 0, 12, 1);
        add(0,0,0,8'h00,0, 1,1,0, 4'd14, 8, 0, 12, 1);
        add(0,0,0,8'h00,0, 0,0,0, 4'd13, 0, 1, 12, 1);
        // POP {r7,PC}, accepted in the first idle cycle after SP_UPD
        add(1,0,1,8'h80,1, 1,0,0, 4'd0,  0, 0, 12, 0);
        add(0,0,0,8'h00,0, 1,1,1, 4'd7,  0, 0,  8, 1);
        add(0,0,0,8'h00,0, 1,1,1, 4'd15, 4, 0,  8, 1);
        add(0,0,0,8'h00,0, 0,0,0, 4'd13, 0, 1,  8, 1);
        // empty list
        add(1,0,0,8'h00,0, 1,0,0, 4'd0,  0, 0,  8, 0);
        add(0,0,0,8'h00,0, 0,0,0, 4'd13, 0, 1,  0, 1);
        add(0,0,0,8'h00,0, 0,0,0, 4'd0,  0, 0,  0, 0);
        // full list with a start pulse mid-sequence
        add(1,0,0,8'hFF,1, 1,0,0, 4'd0,  0, 0,  0, 0);
        for (int k = 0; k < 9; k++) begin
            if (k == 2) add(1,0,1,8'h01,0, 1,1,0, 4'(k), 32'(4*k), 0, 36, 1);
            else        add(0,0,0,8'h00,0, 1,1,0, (k < 8) ? 4'(k) : 4'd14, 32'(4*k), 0, 36, 1);
        end
        add(0,0,0,8'h00,0, 0,0,0, 4'd13, 0, 1, 36, 1);
        add(0,0,0,8'h00,0, 0,0,0, 4'd0,  0, 0, 36, 0);
        // flush after second micro-op of 0x0F
        add(1,0,1,8'h0F,0, 1,0,0, 4'd0,  0, 0, 36, 0);
        add(0,0,0,8'h00,0, 1,1,1, 4'd0,  0, 0, 16, 1);
        add(0,0,0,8'h00,0, 1,1,1, 4'd1,  4, 0, 16, 1);
        add(0,1,0,8'h00,0, 0,0,0, 4'd0,  0, 0, 16, 1);
        add(0,0,0,8'h00,0, 0,0,0, 4'd0,  0, 0, 16, 0);
        add(0,0,0,8'h00,0, 0,0,0, 4'd0,  0, 0, 16, 0);
        // flush beats start in IDLE
        add(1,1,0,8'h03,0, 0,0,0, 4'd0,  0, 0, 16, 0);
        add(0,0,0,8'h00,0, 0,0,0, 4'd0,  0, 0, 16, 0);
        // flush during SP_UPD suppresses the writeback
        add(1,0,0,8'h00,0, 1,0,0, 4'd0,  0, 0, 16, 0);
        add(0,1,0,8'h00,0, 0,0,0, 4'd0,  0, 0,  0, 1);
        add(0,0,0,8'h00,0, 0,0,0, 4'd0,  0, 0,  0, 0);

        reset_i = 1'b0;
        drive(1, 0, 1, 8'hFF, 1);
        #12;
        check_all("in_reset", 0,0,0, 4'd0, 0, 0, 0, 0);
        @(negedge clk_i);
        drive(0, 0, 0, 8'h00, 0);
        reset_i = 1'b1;
        #1;
        check_all("after_reset", 0,0,0, 4'd0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk_i);
            drive(vecs[i].start, vecs[i].flush, vecs[i].ld, vecs[i].list, vecs[i].extra);
            #1;
            check_all($sformatf("row%0d", i), vecs[i].e_stall, vecs[i].e_valid, vecs[i].e_ld,
                      vecs[i].e_addr, vecs[i].e_off, vecs[i].e_spu, vecs[i].e_adj,
                      vecs[i].e_busy);
        end

        // reset asserted in the middle of a sequence
        @(negedge clk_i);
        drive(1, 0, 0, 8'h0F, 0);
        @(negedge clk_i);
        drive(0, 0, 0, 8'h00, 0);
        #1;
        check_all("pre_reset_seq", 1,1,0, 4'd0, 0, 0, 16, 1);
        #1;
        reset_i = 1'b0;
        #1;
        check_all("mid_reset", 0,0,0, 4'd0, 0, 0, 0, 0);
        @(negedge clk_i);
        reset_i = 1'b1;
        #1;
        check_all("post_reset", 0,0,0, 4'd0, 0, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            #1;
            check_all($sformatf("post_reset_idle%0d", c), 0,0,0, 4'd0, 0, 0, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_list_sequencer.md
REG_LIST_SEQUENCER -- requirements
Module: reg_list_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, register address width.
REQ-002 SHALL have parameter WORD, default 32, data/offset width.
REQ-003 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset_i  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start_i  input  1  decode presents a multi-register instruction (PUSH/POP/LDM/STM).
REQ-006 SHALL have port flush_i  input  1  synchronous abort of any sequence in progress.
REQ-007 SHALL have port is_load_i  input  1  1 = POP/LDM (register writes), 0 = PUSH/STM (memory writes).
REQ-008 SHALL have port reg_list_i  input  8  low-register list r0..r7.
REQ-009 SHALL have port extra_reg_i  input  1  include r14 (store) or r15 (load).
REQ-010 SHALL have port stall_pipeline_o  output  1  freezes fetch/decode.
REQ-011 SHALL have port uop_valid_o  output  1  one register transfer micro-op this cycle.
REQ-012 SHALL have port uop_is_load_o  output  1  captured is_load for current micro-op.
REQ-013 SHALL have port reg_addr_o  output  ADDR_WIDTH  register of current micro-op.
REQ-014 SHALL have port offset_o  output  WORD  byte offset of current micro-op from base.
REQ-015 SHALL have port sp_update_o  output  1  base-register writeback micro-op this cycle.
REQ-016 SHALL have port sp_adjust_o  output  WORD  total bytes transferred (4 x register count).
REQ-017 SHALL have port busy_o  output  1  state != IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, SEQ, SP_UPD.
REQ-019 In IDLE, start_i=1 and flush_i=0 SHALL capture reg_list_i, extra_reg_i, is_load_i and compute count = popcount(list)+extra (0..9).
REQ-020 Accept SHALL go to SEQ if count>0, else directly to SP_UPD.
REQ-021 start_i SHALL be ignored outside IDLE; captured fields SHALL NOT change mid-sequence.
REQ-022 In SEQ, each cycle SHALL emit uop_valid_o=1 for the lowest pending register, then clear it.
REQ-023 Order SHALL be ascending r0..r7, then extra register last (r14 when is_load=0, r15 when is_load=1).
REQ-024 offset_o SHALL equal 4 x k, k = zero-based index of the micro-op in the sequence.
REQ-025 After the micro-op with no registers remaining, FSM SHALL go to SP_UPD.
REQ-026 SP_UPD SHALL last exactly one cycle: sp_update_o=1, reg_addr_o=13, sp_adjust_o=4 x count, uop_valid_o=0; then IDLE.
REQ-027 sp_adjust_o SHALL hold 4 x count from accept until the next accept.
REQ-028 stall_pipeline_o SHALL be 1 combinationally in the accept cycle and in every SEQ cycle, and 0 in SP_UPD and idle cycles.
REQ-029 Total latency SHALL be count+1 cycles from the accept edge to return to IDLE.
REQ-030 In cycles with no micro-op, uop_valid_o, sp_update_o, reg_addr_o and offset_o SHALL be 0.
REQ-031 flush_i SHALL return the FSM to IDLE at the next edge from any state, with no further micro-ops or SP_UPD.
REQ-032 flush_i SHALL take priority over start_i in the same cycle, and stall_pipeline_o SHALL be 0 while flush_i=1.
REQ-033 A start_i in the first IDLE cycle after SP_UPD SHALL be accepted with no bubble.

Reset
REQ-034 reset_i=0 SHALL asynchronously force IDLE and clear the captured list, count and sp_adjust.
REQ-035 During reset, all outputs SHALL be 0.
REQ-036 Reset asserted mid-sequence SHALL abort with no further micro-ops after release.

Verification
REQ-037 PUSH {r0,r2,LR}: list=0x05, extra=1, is_load=0 -> micro-ops (r0,0),(r2,4),(r14,8), then SP_UPD with adjust 12; stall high for 4 cycles (accept + 3).
REQ-038 POP {r7,PC}: list=0x80, extra=1, is_load=1 -> micro-ops (r7,0),(r15,4), uop_is_load=1, then SP_UPD with adjust 8.
REQ-039 Full list 0xFF+extra -> 9 micro-ops with offsets 0..32, then adjust 36; start_i pulsed mid-sequence is ignored.
REQ-040 Empty list, extra=0 -> next cycle SP_UPD with adjust 0, no uop_valid, then IDLE.
REQ-041 flush_i after the 2nd micro-op of list 0x0F -> IDLE next edge; no r2/r3 micro-ops and no SP_UPD.
REQ-042 reset_i low during SEQ -> all outputs 0 immediately; after release, IDLE with busy_o=0.
